bp_stall_profiler_counters: RTL and testbench
=============================================

Name: bp_stall_profiler_counters

Overview:
- Synthesizable, multi-core successor to the non-synthesizable per-cycle stall tracer.
- Takes one stall-reason vector per core per cycle and attributes each non-retiring cycle to its lowest-index asserted reason.
- Accumulates saturating per-reason, instret and cycle counters per core, readable through a registered read port.
- Sits beside the cores in the profiling shell. Counters are cleared by a handshaked sweep FSM.

Parameters:
- num_cores_p, 1: number of independently profiled cores.
- num_reasons_p, 32: width of each core's stall-reason vector.
- counter_width_p, 32: width of every counter.
- freeze_delay_p, 8: cycles a core's freeze_i is delayed before it gates counting; 0 means no delay.
- Derived: entries_lp = num_reasons_p+4; addr_width_lp = clog2(entries_lp).

Ports:
- clk_i  in  1  clock.
- reset_li  in  1  reset, asynchronous, active-low.
- en_i  in  1  global count enable.
- freeze_i  in  num_cores_p  per-core freeze.
- instret_i  in  num_cores_p  per-core instruction retired this cycle.
- stall_reason_i  in  num_cores_p*num_reasons_p  per-core reason bits; core c occupies bits [c*num_reasons_p +: num_reasons_p].
- clear_v_i  in  1  clear request.
- clear_ready_o  out  1  clear can be accepted.
- busy_o  out  1  clear sweep in progress.
- rd_v_i  in  1  read request.
- rd_core_i  in  clog2(num_cores_p)  core to read.
- rd_addr_i  in  addr_width_lp  entry to read.
- rd_v_o  out  1  read data valid.
- rd_data_o  out  counter_width_p  read data.
- sat_o  out  num_cores_p  sticky flag: some counter of that core has saturated.

Behaviour:
- Address map per core:
  - 0..R-1: reason counters.
  - R: unattributed (non-retiring cycle with no reason bit set).
  - R+1: instret.
  - R+2: counted cycles.
  - R+3: peak stall run.
  - Addresses >= entries_lp read 0.
- Reset (reset_li low, asynchronous): all counters 0, sat_o 0, FSM in IDLE, clear_ready_o 1, busy_o 0, rd_v_o 0, rd_data_o 0. Freeze delay registers reset to 1, so counting is frozen until a deasserted freeze has propagated.
- Counting qualifier per core c: count_c = en_i & ~frz_d[c] & (state == IDLE), where frz_d is freeze_i delayed by freeze_delay_p flops.
- When count_c is set:
  - Cycles counter increments by 1.
  - If instret_i[c]: instret increments and no reason counter is touched.
  - Otherwise: the reason counter at the lowest set bit index increments; with no bit set, the unattributed counter increments.
- Counters saturate at 2^counter_width_p-1 and never wrap. sat_o[c] sets on the cycle any counter of core c would exceed max, and clears only by reset or clear sweep.
- Read:
  - rd_v_i sampled at a clock edge gives rd_v_o=1 and rd_data_o valid in the following cycle (1-cycle latency), back-to-back reads allowed.
  - The value returned is the counter contents before any same-cycle increment.
  - rd_v_o is 0 when no read was issued. rd_data_o holds its last value.
- Clear FSM:
  - IDLE: clear_ready_o=1. clear_v_i & clear_ready_o moves to SWEEP with idx=0.
  - SWEEP: busy_o=1, clear_ready_o=0. Each cycle zeroes entry idx for all cores and increments idx. After idx=entries_lp-1 it zeroes sat_o and the internal run counters and returns to IDLE, so SWEEP lasts exactly entries_lp cycles.
  - Counting is suppressed for the whole sweep.
  - Reads during SWEEP are accepted and return current, possibly partially cleared, contents.
  - clear_v_i during SWEEP is ignored; no queuing.
- Reset mid-sweep: immediate return to IDLE with all state zero.

Optional Feature:
- Macro BP_STALL_PROFILER_PEAK_EN.
- Defined:
  - A per-core run counter increments on each counted non-instret cycle and resets to 0 on a counted instret cycle.
  - Entry R+3 holds the maximum run value reached. It is updated when the run counter exceeds it and saturates like the other counters.
  - Non-counted cycles neither extend nor break a run.
- Undefined: no run or peak logic is instantiated, and entry R+3 always reads 0.

Test Plan:
- Reset release with freeze_i=0, en_i=1, freeze_delay_p=8 -> cycles counter of core 0 reads 0 for the first 8 cycles after release, then increments by 1 per cycle.
- Core 0, reasons 0x0000_0014 for 5 cycles with instret=0 -> entry 2 = 5, entry 4 = 0, entry R+2 = 5.
- 3 cycles with reasons=0 and instret=0, then 4 cycles with instret=1 and reasons=0xFF -> entry R = 3, entry R+1 = 4, all reason entries 0.
- counter_width_p=4, 20 stall cycles on reason 1 -> entry 1 = 15 and sat_o[0] = 1; a following clear sweep with busy_o high for exactly 36 cycles (R=32) gives all entries 0 and sat_o = 0.
- With BP_STALL_PROFILER_PEAK_EN defined: stall pattern 3, instret, 7, instret, 2 -> entry R+3 = 7. Without the macro -> entry R+3 = 0.
- num_cores_p=2: clear_v_i asserted during a read stream, and reset_li pulsed low mid-sweep -> rd_v_o one cycle after each rd_v_i, core 1 counters independent of core 0, and after reset clear_ready_o = 1 with all counters 0.

Source files
------------

// File: rtl/bp_stall_profiler_counters.sv
// Per-core stall-reason profiler: saturating reason/instret/cycle counters, registered read port, clear sweep FSM.
// Optional macro BP_STALL_PROFILER_PEAK_EN adds the per-core peak stall-run entry at address num_reasons_p+3.
module bp_stall_profiler_counters #(
  parameter int unsigned num_cores_p     = 1,
  parameter int unsigned num_reasons_p   = 32,
  parameter int unsigned counter_width_p = 32,
  parameter int unsigned freeze_delay_p  = 8,
  localparam int unsigned entries_lp     = num_reasons_p + 4,
  localparam int unsigned addr_width_lp  = $clog2(entries_lp),
  localparam int unsigned core_width_lp  = (num_cores_p > 1) ? $clog2(num_cores_p) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_li,
  input  logic                                     en_i,
  input  logic [num_cores_p-1:0]                   freeze_i,
  input  logic [num_cores_p-1:0]                   instret_i,
  input  logic [num_cores_p*num_reasons_p-1:0]     stall_reason_i,
  input  logic                                     clear_v_i,
  output logic                                     clear_ready_o,
  output logic                                     busy_o,
  input  logic                                     rd_v_i,
  input  logic [core_width_lp-1:0]                 rd_core_i,
  input  logic [addr_width_lp-1:0]                 rd_addr_i,
  output logic                                     rd_v_o,
  output logic [counter_width_p-1:0]               rd_data_o,
  output logic [num_cores_p-1:0]                   sat_o
);

  localparam int unsigned unattr_lp  = num_reasons_p;
  localparam int unsigned instret_lp = num_reasons_p + 1;
  localparam int unsigned cycles_lp  = num_reasons_p + 2;
`ifdef BP_STALL_PROFILER_PEAK_EN
  localparam int unsigned peak_lp       = num_reasons_p + 3;
  localparam int unsigned rd_entries_lp = entries_lp;
`else
  localparam int unsigned rd_entries_lp = entries_lp - 1;
`endif
  localparam logic [counter_width_p-1:0] max_lp = '1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_e;

  state_e                     state_q, state_n;
  logic [addr_width_lp-1:0]   idx_q;
  logic                       sweep_last;
  logic                       clear_ready_q, busy_q, clear_ready_n, busy_n;

  logic [num_cores_p-1:0]     frz_d;
  logic [num_cores_p-1:0]     count;
  logic [addr_width_lp-1:0]   tgt [num_cores_p];

  logic [counter_width_p-1:0] cnt_q [num_cores_p][entries_lp];
  logic [num_cores_p-1:0]     sat_q;
`ifdef BP_STALL_PROFILER_PEAK_EN
  logic [counter_width_p-1:0] run_q [num_cores_p];
`endif

  logic                       rd_v_q;
  logic [counter_width_p-1:0] rd_data_q, rd_mux;

  assign sweep_last = (idx_q == addr_width_lp'(entries_lp - 1));

  // Clear FSM state register and sweep index
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= (state_q == ST_SWEEP && !sweep_last) ? idx_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (clear_v_i && clear_ready_q) state_n = ST_SWEEP;
      ST_SWEEP: if (sweep_last) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_ready_n = 1'b0;
    busy_n        = 1'b0;
    if (state_n == ST_IDLE) clear_ready_n = 1'b1;
    else                    busy_n        = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      clear_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      clear_ready_q <= clear_ready_n;
      busy_q        <= busy_n;
    end
  end

  // Freeze delay line resets frozen so counting waits for a released freeze to propagate
  generate
    if (freeze_delay_p == 0) begin : g_no_frz_dly
      assign frz_d = freeze_i;
    end else begin : g_frz_dly
      logic [num_cores_p-1:0] frz_q [freeze_delay_p];
      always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
          for (int unsigned i = 0; i < freeze_delay_p; i++) frz_q[i] <= '1;
        end else begin
          frz_q[0] <= freeze_i;
          for (int unsigned i = 1; i < freeze_delay_p; i++) frz_q[i] <= frz_q[i-1];
        end
      end
      assign frz_d = frz_q[freeze_delay_p-1];
    end
  endgenerate

  // Count qualifier and attributed entry; lowest set reason bit wins
  always_comb begin
    count = '0;
    for (int unsigned c = 0; c < num_cores_p; c++) begin
      count[c] = en_i & ~frz_d[c] & (state_q == ST_IDLE);
      tgt[c]   = addr_width_lp'(unattr_lp);
      if (instret_i[c]) begin
        tgt[c] = addr_width_lp'(instret_lp);
      end else begin
        for (int r = int'(num_reasons_p) - 1; r >= 0; r--) begin
          if (stall_reason_i[c*num_reasons_p + $unsigned(r)]) tgt[c] = addr_width_lp'(r);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int unsigned c = 0; c < num_cores_p; c++) begin
        for (int unsigned e = 0; e < entries_lp; e++) cnt_q[c][e] <= '0;
`ifdef BP_STALL_PROFILER_PEAK_EN
        run_q[c] <= '0;
`endif
      end
      sat_q <= '0;
    end else if (state_q == ST_SWEEP) begin
      for (int unsigned c = 0; c < num_cores_p; c++) cnt_q[c][idx_q] <= '0;
      if (sweep_last) begin
        sat_q <= '0;
`ifdef BP_STALL_PROFILER_PEAK_EN
        for (int unsigned c = 0; c < num_cores_p; c++) run_q[c] <= '0;
`endif
      end
    end else begin
      for (int unsigned c = 0; c < num_cores_p; c++) begin
        if (count[c]) begin
          if (cnt_q[c][cycles_lp] == max_lp) sat_q[c] <= 1'b1;
          else cnt_q[c][cycles_lp] <= cnt_q[c][cycles_lp] + 1'b1;
          if (cnt_q[c][tgt[c]] == max_lp) sat_q[c] <= 1'b1;
          else cnt_q[c][tgt[c]] <= cnt_q[c][tgt[c]] + 1'b1;
`ifdef BP_STALL_PROFILER_PEAK_EN
          // Run breaks on retire; the peak follows it upward and saturates with it
          if (instret_i[c]) begin
            run_q[c] <= '0;
          end else if (run_q[c] == max_lp) begin
            sat_q[c] <= 1'b1;
          end else begin
            run_q[c] <= run_q[c] + 1'b1;
            if (counter_width_p'(run_q[c] + 1'b1) > cnt_q[c][peak_lp])
              cnt_q[c][peak_lp] <= counter_width_p'(run_q[c] + 1'b1);
          end
`endif
        end
      end
    end
  end

  // Read mux; unmapped addresses and cores return 0
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < num_cores_p; c++) begin
      for (int unsigned e = 0; e < rd_entries_lp; e++) begin
        if (rd_core_i == core_width_lp'(c) && rd_addr_i == addr_width_lp'(e)) rd_mux = cnt_q[c][e];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_v_q <= rd_v_i;
      if (rd_v_i) rd_data_q <= rd_mux;
    end
  end

  assign clear_ready_o = clear_ready_q;
  assign busy_o        = busy_q;
  assign rd_v_o        = rd_v_q;
  assign rd_data_o     = rd_data_q;
  assign sat_o         = sat_q;

endmodule

// File: tb/tb_bp_stall_profiler_counters.sv
// Scoreboard bench for bp_stall_profiler_counters: two cores, 8-bit counters, freeze delay 8.
module tb_bp_stall_profiler_counters;

  localparam int unsigned nc_lp  = 2;
  localparam int unsigned nr_lp  = 32;
  localparam int unsigned cw_lp  = 8;
  localparam int unsigned fd_lp  = 8;
  localparam int unsigned ent_lp = nr_lp + 4;
  localparam int unsigned aw_lp  = $clog2(ent_lp);
`ifdef BP_STALL_PROFILER_PEAK_EN
  localparam int peak0_lp = 7;
  localparam int peak1_lp = 14;
`else
  localparam int peak0_lp = 0;
  localparam int peak1_lp = 0;
`endif

  logic                    clk_i = 1'b0;
  logic                    reset_li;
  logic                    en_i;
  logic [nc_lp-1:0]        freeze_i;
  logic [nc_lp-1:0]        instret_i;
  logic [nc_lp*nr_lp-1:0]  stall_reason_i;
  logic                    clear_v_i;
  logic                    clear_ready_o;
  logic                    busy_o;
  logic                    rd_v_i;
  logic [0:0]              rd_core_i;
  logic [aw_lp-1:0]        rd_addr_i;
  logic                    rd_v_o;
  logic [cw_lp-1:0]        rd_data_o;
  logic [nc_lp-1:0]        sat_o;

  bp_stall_profiler_counters #(
    .num_cores_p(nc_lp), .num_reasons_p(nr_lp), .counter_width_p(cw_lp), .freeze_delay_p(fd_lp)
  ) dut (
    .clk_i(clk_i), .reset_li(reset_li), .en_i(en_i), .freeze_i(freeze_i), .instret_i(instret_i),
    .stall_reason_i(stall_reason_i), .clear_v_i(clear_v_i), .clear_ready_o(clear_ready_o),
    .busy_o(busy_o), .rd_v_i(rd_v_i), .rd_core_i(rd_core_i), .rd_addr_i(rd_addr_i),
    .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .sat_o(sat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int               core;
    int               addr;
    logic [cw_lp-1:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic exp_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic rd(input int core, input int addr, input int v);
    exp_t e;
    rd_v_i    = 1'b1;
    rd_core_i = 1'(core);
    rd_addr_i = aw_lp'(addr);
    e.core = core;
    e.addr = addr;
    e.val  = cw_lp'(v);
    sb.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic step(input logic [nr_lp-1:0] r0, input logic i0,
                      input logic [nr_lp-1:0] r1, input logic i1, input int n);
    en_i           = 1'b1;
    stall_reason_i = {r1, r0};
    instret_i      = {i1, i0};
    repeat (n) @(negedge clk_i);
    en_i           = 1'b0;
    stall_reason_i = '0;
    instret_i      = '0;
  endtask

  // Request a clear, hold it for `hold` cycles, and measure how long busy stays up
  task automatic do_clear(input int hold);
    int n;
    n = 0;
    rd_v_i = 1'b0;
    chk("clear_ready_idle", 32'(clear_ready_o), 32'd1);
    clear_v_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (i == hold - 1) clear_v_i = 1'b0;
      if (i == 4) chk("clear_ready_sweep", 32'(clear_ready_o), 32'd0);
      if (busy_o) n++;
      else if (n > 0) break;
    end
    clear_v_i = 1'b0;
    chk("busy_len", n, 32'd36);
    chk("clear_ready_after", 32'(clear_ready_o), 32'd1);
  endtask

  // A read sampled at an edge must be answered in the next cycle
  always @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) exp_v <= 1'b0;
    else           exp_v <= rd_v_i;
  end

  always @(negedge clk_i) begin
    if (exp_v || rd_v_o) chk("rd_v_o", 32'(rd_v_o), 32'(exp_v));
    if (rd_v_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got data %0d with nothing outstanding", rd_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("rd core%0d addr%0d", mon_e.core, mon_e.addr), 32'(rd_data_o), 32'(mon_e.val));
      end
    end
  end

  initial begin
    reset_li = 1'b0; en_i = 1'b1; freeze_i = '0; instret_i = '0; stall_reason_i = '0;
    clear_v_i = 1'b0; rd_v_i = 1'b0; rd_core_i = '0; rd_addr_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_clear_ready", 32'(clear_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rd_v", 32'(rd_v_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    chk("rst_sat", 32'(sat_o), 32'd0);

    // Freeze delay after reset: cycles counter stays 0 for 8 cycles, then counts
    reset_li = 1'b1;
    for (int k = 0; k < 12; k++) rd(0, 34, (k <= 8) ? 0 : k - 8);
    rd_v_i = 1'b0;
    en_i   = 1'b0;
    do_clear(1);

    // Lowest reason wins on core 0; core 1 retires meanwhile
    step(32'h0000_0014, 1'b0, 32'h0, 1'b1, 5);
    rd(0, 2, 5); rd(0, 4, 0); rd(0, 34, 5); rd(0, 32, 0);
    rd(1, 33, 5); rd(1, 34, 5); rd(1, 2, 0); rd(0, 36, 0); rd(1, 63, 0);
    rd_v_i = 1'b0;
    do_clear(1);

    // Unattributed, then retiring cycles with reasons that must be ignored
    step(32'h0, 1'b0, 32'h8000_0000, 1'b0, 3);
    step(32'hFF, 1'b1, 32'h8000_0000, 1'b0, 4);
    for (int a = 0; a < 32; a++) rd(0, a, 0);
    rd(0, 32, 3); rd(0, 33, 4); rd(0, 34, 7);
    rd(1, 31, 7); rd(1, 32, 0); rd(1, 34, 7);
    rd_v_i = 1'b0;
    chk("sat_none", 32'(sat_o), 32'd0);

    // Freeze core 1 only
    freeze_i = 2'b10;
    repeat (10) @(negedge clk_i);
    step(32'h0, 1'b0, 32'h0, 1'b0, 5);
    rd(0, 34, 12); rd(1, 34, 7);
    rd_v_i   = 1'b0;
    freeze_i = '0;
    repeat (10) @(negedge clk_i);
    do_clear(1);

    // Peak stall run: 3, retire, 7, retire, 2
    step(32'h1, 1'b0, 32'h0, 1'b0, 3);
    step(32'h0, 1'b1, 32'h0, 1'b0, 1);
    step(32'h1, 1'b0, 32'h0, 1'b0, 7);
    step(32'h0, 1'b1, 32'h0, 1'b0, 1);
    step(32'h1, 1'b0, 32'h0, 1'b0, 2);
    rd(0, 35, peak0_lp); rd(1, 35, peak1_lp); rd(0, 0, 12); rd(0, 33, 2); rd(1, 32, 14);
    rd_v_i = 1'b0;
    do_clear(1);

    // Saturation, then a clear held across the sweep
    step(32'h2, 1'b0, 32'h0, 1'b0, 260);
    chk("sat_set", 32'(sat_o), 32'd3);
    rd(0, 1, 255); rd(0, 34, 255); rd(1, 32, 255);
    rd_v_i = 1'b0;
    do_clear(10);
    chk("sat_cleared", 32'(sat_o), 32'd0);
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 36; a++) rd(c, a, 0);
    rd_v_i = 1'b0;

    // Clear during a read stream, then reset mid-sweep
    step(32'h0, 1'b0, 32'h20, 1'b0, 3);
    chk("clear_ready_pre", 32'(clear_ready_o), 32'd1);
    clear_v_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rd(1, 5, (k <= 6) ? 3 : 0);
      clear_v_i = 1'b0;
    end
    rd_v_i = 1'b0;
    @(negedge clk_i);
    chk("mid_sweep_busy", 32'(busy_o), 32'd1);
    chk("mid_sweep_ready", 32'(clear_ready_o), 32'd0);
    #1 reset_li = 1'b0;
    #1;
    chk("rst_sweep_ready", 32'(clear_ready_o), 32'd1);
    chk("rst_sweep_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    reset_li = 1'b1;
    @(negedge clk_i);
    rd(1, 5, 0); rd(1, 34, 0); rd(0, 34, 0); rd(0, 1, 0);
    rd_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("final_ready", 32'(clear_ready_o), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
